// File: rtl/ov2640_pkg.sv
// ---------------------------------------------------------------------------
// ov2640_pkg
// Shared types and constants for the OV2640 SCCB configuration controller.
//   state_e      : controller FSM states
//   reg_entry_t  : one register-table entry {reg_addr, reg_data}
//   END_MARK     : table entry that terminates the sequence
//   DELAY_MARK   : table entry that inserts a quiet wait on the bus
//   build_frame  : packs one 3-phase write into the 27 shifted bit slots
// ---------------------------------------------------------------------------
package ov2640_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_SEND,
        ST_STOP,
        ST_GAP,
        ST_DELAY,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } reg_entry_t;

    localparam reg_entry_t END_MARK   = 16'hFFFF;
    localparam reg_entry_t DELAY_MARK = 16'hFFF0;

    localparam int IDX_W = 8;
    typedef logic [IDX_W-1:0] rom_idx_t;

    // DEV_ID, don't-care, reg_addr, don't-care, reg_data, don't-care.
    localparam int FRAME_BITS = 27;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // Don't-care slots are driven high so the bus never sees a forced ACK.
    function automatic frame_t build_frame(input logic [7:0] dev_id,
                                           input reg_entry_t entry);
        return {dev_id, 1'b1, entry.reg_addr, 1'b1, entry.reg_data, 1'b1};
    endfunction

endpackage

// File: rtl/ov2640_registers.sv
// ---------------------------------------------------------------------------
// ov2640_registers
// Combinational register table for the OV2640 bring-up sequence.
//   index_i : table index, 0 is the first entry
//   entry_o : {reg_addr, reg_data}; END_MARK past the last entry
// The sequence selects sensor bank, soft-resets the sensor, waits, then
// programs a short DSP/sensor init list.
// ---------------------------------------------------------------------------
module ov2640_registers
    import ov2640_pkg::*;
(
    input  rom_idx_t   index_i,
    output reg_entry_t entry_o
);

    // NOTE: the table is pure combinational decode with no storage, so there
    // is nothing to reset; only registered state takes a reset value.
    always_comb begin
        // NOTE: every path through an always_comb must assign its outputs;
        // the default here keeps synthesis from inferring a latch.
        entry_o = END_MARK;
        case (index_i)
            8'd0:    entry_o = 16'hFF01;   // bank select: sensor
            8'd1:    entry_o = 16'h1280;   // COM7 soft reset
            8'd2:    entry_o = DELAY_MARK; // let the sensor come out of reset
            8'd3:    entry_o = 16'hFF00;   // bank select: DSP
            8'd4:    entry_o = 16'h2CFF;
            8'd5:    entry_o = 16'h2EDF;
            8'd6:    entry_o = 16'hFF01;   // bank select: sensor
            8'd7:    entry_o = 16'h3C32;
            8'd8:    entry_o = 16'h1100;   // CLKRC
            8'd9:    entry_o = 16'h0902;   // COM2 output drive
            8'd10:   entry_o = 16'h0428;   // REG04
            8'd11:   entry_o = 16'h13E5;   // COM8 AGC/AEC
            8'd12:   entry_o = 16'h1448;   // COM9 gain ceiling
            8'd13:   entry_o = END_MARK;
            default: entry_o = END_MARK;
        endcase
    end

endmodule

// File: rtl/ov2640_controller.sv
// ---------------------------------------------------------------------------
// ov2640_controller
// Walks the OV2640 register table after reset and writes every entry over
// SCCB as a 3-phase write, honouring delay entries, then signals completion.
//   clk             : system clock, rising edge
//   rst             : synchronous active-high reset
//   resend          : one-cycle pulse, replays the whole table from entry 0
//   config_finished : high while the whole table has been written
//   sioc / siod     : SCCB clock and data, idle high, registered
//   reset           : camera RESETB, tied inactive (1)
//   pwdn            : camera power-down, tied inactive (0)
// ---------------------------------------------------------------------------
module ov2640_controller
    import ov2640_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 27_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000,
    parameter int unsigned DELAY_CYCLES = CLK_FREQ_HZ / 100,
    parameter logic [7:0]  DEV_ID       = 8'h60
) (
    input  logic clk,
    input  logic rst,
    input  logic resend,
    output logic config_finished,
    output logic sioc,
    output logic siod,
    output logic reset,
    output logic pwdn
);

    localparam int unsigned QUARTER  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int          QCNT_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QCNT_W-1:0] Q_LAST = QCNT_W'(QUARTER - 1);
    localparam logic [31:0] D_LAST   = 32'(DELAY_CYCLES - 1);
    localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS - 1);

    state_e            state_q, state_d;
    rom_idx_t          idx_q;
    reg_entry_t        entry;
    logic [QCNT_W-1:0] qcnt_q;
    logic [1:0]        phase_q;
    logic [4:0]        bit_q;
    logic [31:0]       dly_q;
    frame_t            frame_q;
    logic              pend_q;
    logic              sioc_q, siod_q;
    logic              sioc_d, siod_d;

    logic in_slot, q_last, slot_last, dly_last, restart_req;

    ov2640_registers u_registers (
        .index_i (idx_q),
        .entry_o (entry)
    );

    // A bit slot is four quarters; phase_q names the quarter within the slot.
    assign in_slot   = state_q inside {ST_START, ST_SEND, ST_STOP, ST_GAP};
    assign q_last    = (qcnt_q == Q_LAST);
    assign slot_last = q_last && (phase_q == 2'd3);
    assign dly_last  = (dly_q == D_LAST);

    // A resend seen now, or one held back until the current write/delay ended.
    assign restart_req = resend | pend_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (restart_req)               state_d = ST_IDLE;
                else if (entry == END_MARK)    state_d = ST_DONE;
                else if (entry == DELAY_MARK)  state_d = ST_DELAY;
                else                           state_d = ST_START;
            end
            ST_START: if (slot_last) state_d = ST_SEND;
            ST_SEND:  if (slot_last && (bit_q == LAST_BIT)) state_d = ST_STOP;
            ST_STOP:  if (slot_last) state_d = ST_GAP;
            ST_GAP:   if (slot_last) state_d = restart_req ? ST_IDLE : ST_FETCH;
            ST_DELAY: if (dly_last)  state_d = restart_req ? ST_IDLE : ST_FETCH;
            ST_DONE:  if (resend)    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    // START: 1/1, 1/0, 1/0, 0/0 -> data falls while clock is high.
    // SEND : clock low for two quarters then high; data held for the slot.
    // STOP : 0/0, 1/0, 1/1, 1/1 -> data rises while clock is high.
    always_comb begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        unique case (state_q)
            ST_START: begin
                sioc_d = (phase_q != 2'd3);
                siod_d = (phase_q == 2'd0);
            end
            ST_SEND: begin
                sioc_d = phase_q[1];
                siod_d = frame_q[FRAME_BITS-1];
            end
            ST_STOP: begin
                sioc_d = (phase_q != 2'd0);
                siod_d = phase_q[1];
            end
            default: ;
        endcase
    end

    assign sioc            = sioc_q;
    assign siod            = siod_q;
    assign config_finished = (state_q == ST_DONE);
    assign reset           = 1'b1;
    assign pwdn            = 1'b0;

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            qcnt_q  <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            dly_q   <= '0;
            frame_q <= '1;
            pend_q  <= 1'b0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
        end else begin
            sioc_q <= sioc_d;
            siod_q <= siod_d;

            // Every exit from a slot state happens on slot_last, so the
            // quarter counter and phase are back at zero when a new one starts.
            if (in_slot) begin
                if (q_last) begin
                    qcnt_q  <= '0;
                    phase_q <= phase_q + 2'd1;
                end else begin
                    qcnt_q <= qcnt_q + QCNT_W'(1);
                end
            end

            if (state_q == ST_FETCH) begin
                frame_q <= build_frame(DEV_ID, entry);
            end else if ((state_q == ST_SEND) && slot_last) begin
                frame_q <= {frame_q[FRAME_BITS-2:0], 1'b1};
                bit_q   <= (bit_q == LAST_BIT) ? 5'd0 : bit_q + 5'd1;
            end

            if (state_q == ST_DELAY) begin
                dly_q <= dly_last ? 32'd0 : dly_q + 32'd1;
            end

            if (state_d == ST_IDLE)  pend_q <= 1'b0;
            else if (resend)         pend_q <= 1'b1;

            if (state_d == ST_IDLE) begin
                idx_q <= '0;
            end else if ((state_d == ST_FETCH) &&
                         ((state_q == ST_GAP) || (state_q == ST_DELAY))) begin
                idx_q <= idx_q + rom_idx_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_ov2640_controller.sv
// ---------------------------------------------------------------------------
// tb_ov2640_controller
// Directed bench for ov2640_controller. Expected SCCB frames are pushed to a
// scoreboard queue when a (re)start is driven; a bus decoder recovers each
// frame from sioc/siod and pops/compares it. Also checks reset values, bus
// idle between writes, the delay gap, completion and resend/rst behaviour.
// ---------------------------------------------------------------------------
module tb_ov2640_controller;

    localparam int Q = 2;     // 100 MHz / (4 * 12.5 MHz)
    localparam int D = 300;   // delay entry length in cycles
    localparam int N_TBL = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resend = 1'b0;
    logic config_finished, sioc, siod, cam_reset, pwdn;

    always #5 clk = ~clk;

    ov2640_controller #(
        .CLK_FREQ_HZ  (100_000_000),
        .SCCB_FREQ_HZ (12_500_000),
        .DELAY_CYCLES (D),
        .DEV_ID       (8'h60)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .resend          (resend),
        .config_finished (config_finished),
        .sioc            (sioc),
        .siod            (siod),
        .reset           (cam_reset),
        .pwdn            (pwdn)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [26:0] frame;
        bit          after_delay;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_stop = -1;
    int   n_frames = 0;

    logic [15:0] tbl [N_TBL] = '{
        16'hFF01, 16'h1280, 16'hFFF0, 16'hFF00, 16'h2CFF, 16'h2EDF, 16'hFF01,
        16'h3C32, 16'h1100, 16'h0902, 16'h0428, 16'h13E5, 16'h1448, 16'hFFFF
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard model: one expected frame per non-marker entry up to FFFF.
    task automatic push_all();
        bit   dly = 1'b0;
        exp_t e;
        for (int i = 0; i < N_TBL; i++) begin
            if (tbl[i] == 16'hFFFF) break;
            if (tbl[i] == 16'hFFF0) begin
                dly = 1'b1;
            end else begin
                e.frame       = {8'h60, 1'b1, tbl[i][15:8], 1'b1, tbl[i][7:0], 1'b1};
                e.after_delay = dly;
                exp_q.push_back(e);
                dly = 1'b0;
            end
        end
    endtask

    // Decode one SCCB frame. got = {sioc rises seen, 27 data bits}; a clean
    // frame has 28 rises (27 data slots plus the STOP slot's clock).
    // act_at > 0: after that many rises, pulse resend (act_rst=0) or assert rst.
    task automatic capture(input int act_at, input bit act_rst,
                           output logic [34:0] got, output bit ok, output bit aborted,
                           output int toggles, output int t_start, output int t_stop);
        bit          in_frame = 1'b0;
        int          nbits = 0;
        logic [31:0] bits = '0;
        logic        ps, pd;
        int          budget = 1000;
        got = '0; ok = 1'b0; aborted = 1'b0; toggles = 0; t_start = 0; t_stop = 0;
        ps = sioc; pd = siod;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (resend) resend = 1'b0;
            if (!in_frame) begin
                if (sioc !== ps) toggles++;
                if (ps && pd && sioc && !siod) begin
                    in_frame = 1'b1; nbits = 0; bits = '0; t_start = cyc;
                end
            end else if (ps && pd && sioc && !siod) begin
                got = {8'(nbits), bits[26:0]}; ok = 1'b1;   // restarted mid-frame
                return;
            end else if (sioc && !ps) begin
                bits = {bits[30:0], siod};
                nbits++;
                if (nbits == act_at) begin
                    if (act_rst) begin
                        rst = 1'b1;
                        got = {8'(nbits), bits[26:0]}; ok = 1'b1; aborted = 1'b1;
                        return;
                    end
                    resend = 1'b1;
                    // Current frame still completes, then the table replays.
                    while (exp_q.size() > 1) void'(exp_q.pop_back());
                    push_all();
                end
            end else if (sioc && ps && !pd && siod) begin
                t_stop = cyc;
                got = {8'(nbits), bits[27:1]}; ok = 1'b1;
                return;
            end
            ps = sioc; pd = siod;
        end
    endtask

    task automatic do_frame(input int act_at, input bit act_rst, output bit aborted);
        logic [34:0] got;
        bit          ok;
        int          tog, ts, tp, gap;
        exp_t        e;
        capture(act_at, act_rst, got, ok, aborted, tog, ts, tp);
        check("frame_seen", ok, 1);
        if (!ok) return;
        check("idle_no_toggle", tog, 0);
        if (aborted) begin
            exp_q.delete();
            return;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.frame = '0; e.after_delay = 1'b0;
        end
        check("frame", got, {8'd28, e.frame});
        check("cfg_low_busy", config_finished, 0);
        if (last_stop >= 0) begin
            gap = ts - last_stop;
            if (e.after_delay) check("delay_gap", gap, (gap >= D && gap <= D + 10*Q + 4) ? gap : -1);
            else               check("idle_gap", gap, (gap >= 4*Q && gap < D) ? gap : -1);
        end
        last_stop = tp;
        n_frames++;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        int bad = 0;
        while (config_finished !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cfg_rise", config_finished, 1);
        check("write_count", n_frames, n);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (config_finished !== 1'b1 || sioc !== 1'b1 || siod !== 1'b1) bad++;
        end
        check("done_hold_idle", bad, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic run_all();
        int n = exp_q.size();
        bit ab;
        n_frames = 0;
        for (int i = 0; i < n; i++) do_frame(-1, 1'b0, ab);
        wait_done(n);
    endtask

    initial begin
        bit ab;
        rst = 1'b1;
        resend = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_sioc", sioc, 1);
        check("rst_siod", siod, 1);
        check("rst_cfg", config_finished, 0);
        check("cam_reset", cam_reset, 1);
        check("cam_pwdn", pwdn, 0);

        // Startup without resend.
        push_all(); last_stop = -1;
        rst = 1'b0;
        run_all();

        // Resend after DONE: flag drops next cycle, table replays.
        resend = 1'b1; push_all(); last_stop = -1;
        @(negedge clk);
        resend = 1'b0;
        check("resend_cfg_clear", config_finished, 0);
        run_all();

        // Resend during a write: that write ends cleanly, then entry 0 again.
        resend = 1'b1; push_all(); last_stop = -1;
        @(negedge clk);
        resend = 1'b0;
        do_frame(10, 1'b0, ab);
        run_all();

        // rst during a write: bus idles on the next edge, then full restart.
        resend = 1'b1; push_all(); last_stop = -1;
        @(negedge clk);
        resend = 1'b0;
        do_frame(8, 1'b1, ab);
        check("rst_abort_hit", ab, 1);
        @(negedge clk);
        check("abort_sioc", sioc, 1);
        check("abort_siod", siod, 1);
        check("abort_cfg", config_finished, 0);
        repeat (3) @(negedge clk);
        push_all(); last_stop = -1;
        rst = 1'b0;
        run_all();
        check("end_cam_reset", cam_reset, 1);
        check("end_pwdn", pwdn, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
